regfile_wb_bypass: RTL

//  32 x 32-bit register file with a registered (write-buffered) write port and two

---
 rtl/regfile_wb_bypass_pkg.sv | 31 +++
 rtl/regfile_wb_bypass_if.sv | 37 +++
 rtl/regfile_wb_bypass_cell.sv | 28 ++
 rtl/regfile_wb_bypass.sv | 76 +++++++
 4 files changed

// File: rtl/regfile_wb_bypass_pkg.sv
// Shared constants, types and the commit decode
// for the write-buffered register file.
package regfile_wb_bypass_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t R0 = '0;

  typedef struct packed {
    logic  vld;
    addr_t addr;
    data_t data;
  } wbuf_t;

  // r0 has no storage, so the decode starts at bit 1
  function automatic logic [NUM_REGS-1:1] wr_decode(
    input addr_t a
  );
    logic [NUM_REGS-1:1] oh;
    for (int i = 1; i < NUM_REGS; i++) begin
      oh[i] = (a == addr_t'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wb_bypass_if.sv
// Writeback/decode-facing bundle of the
// register file: one write port, two read ports.
interface regfile_wb_bypass_if;
  import regfile_wb_bypass_pkg::*;

  logic  ctrl_writeEnable;
  addr_t ctrl_writeReg;
  data_t data_writeReg;
  addr_t ctrl_readRegA;
  addr_t ctrl_readRegB;
  data_t data_readRegA;
  data_t data_readRegB;
  logic  write_pending;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    input  data_readRegA,
    input  data_readRegB,
    input  write_pending
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    output data_readRegA,
    output data_readRegB,
    output write_pending
  );

endinterface

// File: rtl/regfile_wb_bypass_cell.sv
// Single architectural register: load-enabled
// flop with asynchronous active-low clear.
module reg_cell_32
  import regfile_wb_bypass_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  data_t d,
  output data_t q
);

  data_t val_q;
  data_t val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/regfile_wb_bypass.sv
// 32x32 register file with a one-entry write
// buffer, bypassed reads and hardwired r0.
module regfile_wb_bypass
  import regfile_wb_bypass_pkg::*;
(
  input  logic clock,
  input  logic ctrl_reset_n,
  regfile_wb_bypass_if.slave rf_if
);

  wbuf_t wb_q;
  wbuf_t wb_d;
  logic  cap;

  logic [NUM_REGS-1:1] commit_en;
  data_t               rf [NUM_REGS];

  always_comb begin
    cap = rf_if.ctrl_writeEnable &&
          (rf_if.ctrl_writeReg != R0);
    wb_d     = wb_q;
    wb_d.vld = 1'b0;
    if (cap) begin
      wb_d.vld  = 1'b1;
      wb_d.addr = rf_if.ctrl_writeReg;
      wb_d.data = rf_if.data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) wb_q <= '0;
    else               wb_q <= wb_d;
  end

  always_comb begin
    commit_en = '0;
    if (wb_q.vld) commit_en = wr_decode(wb_q.addr);
  end

  assign rf[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
    reg_cell_32 u_cell (
      .clk   (clock),
      .rst_n (ctrl_reset_n),
      .en    (commit_en[i]),
      .d     (wb_q.data),
      .q     (rf[i])
    );
  end

  // Buffer holds the newest value until it lands
  function automatic data_t rd_port(
    input addr_t a,
    input wbuf_t wb,
    input data_t arr
  );
    data_t r;
    unique case (1'b1)
      (a == R0):                  r = '0;
      (wb.vld && wb.addr == a):   r = wb.data;
      default:                    r = arr;
    endcase
    return r;
  endfunction

  assign rf_if.data_readRegA =
    rd_port(rf_if.ctrl_readRegA, wb_q,
            rf[rf_if.ctrl_readRegA]);
  assign rf_if.data_readRegB =
    rd_port(rf_if.ctrl_readRegB, wb_q,
            rf[rf_if.ctrl_readRegB]);

  assign rf_if.write_pending = wb_q.vld;

endmodule
